reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
Shares one WIDTH-bit enabled storage register between NUM_REQ independent writers. Arbitration is round-robin with a bounded burst: the current owner may write up to MAX_HOLD consecutive cycles before ownership rotates. The block sits between multiple producer blocks and a single shared configuration/data register. The registered value and the current owner are visible to all consumers.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width of shared register
MAX_HOLD, 4, max consecutive writes per ownership (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
req  in  NUM_REQ  per-requester write request, level, held until acked
wdata  in  NUM_REQ x WIDTH  per-requester write data, valid while req high
ack  out  NUM_REQ  one-hot-or-zero; ack[i]=1 means wdata[i] is written this cycle
out  out  WIDTH  shared register value
owner  out  $clog2(NUM_REQ)  index of current owner
owner_valid  out  1  1 when state is OWNED

Behaviour:
- Reset (rst=0, async): out=0, owner=0, owner_valid=0, rr pointer=0, hold_cnt=0, state IDLE, ack=0. All acks drop immediately, including mid-burst. First edge after release behaves as IDLE.
- States: IDLE, OWNED.
- Winner search: first i with req[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
- IDLE: ack=0, owner_valid=0. If any req=1, next edge: state OWNED, owner=winner(ptr), hold_cnt=0. Otherwise stay in IDLE.
- OWNED: ack[owner]=req[owner] (combinational); all other acks are 0. When ack[owner]=1, out<=wdata[owner] at the next edge and hold_cnt increments.
- Release condition: req[owner]=0, or (ack[owner]=1 and hold_cnt==MAX_HOLD-1).
- On release: ptr<=owner+1 (mod NUM_REQ). Search the current-cycle req starting at owner+1, excluding no one.
  - Winner found: stay in OWNED, owner=winner, hold_cnt=0.
  - No winner: go to IDLE.
- Hold expiry when only the owner requests: the owner re-wins and hold_cnt resets to 0. No bubble cycle.
- No release: owner and ptr unchanged.
- Latency: req rising in IDLE at edge n -> ack at cycle n+1 -> out updated at edge n+2. Handoff between owners adds zero idle cycles.
- Data: out changes only on an ack cycle. No arithmetic on data; widths fixed at WIDTH. owner wrap is modulo NUM_REQ (NUM_REQ need not be a power of 2).
- ack is never asserted for a requester whose req is 0. ack is at most one-hot (checked by assertion).

Decomposition:
- Package reg_write_arbiter_pkg: state enum (IDLE, OWNED); function next_winner(req, start) returning {found, index}.
- Sub-module rr_search: combinational rotating priority search (req, start -> found, index). Used twice (from ptr in IDLE, from owner+1 on release).
- Storage register and FSM live in the top module.

Test Plan:
- Reset, then req=0001, wdata[0]=8'hA5 -> ack[0] at cycle 1 after req, out=8'hA5 the following edge, owner=0, owner_valid=1.
- req=1111 held continuously, distinct data per requester, MAX_HOLD=4 -> owners 0,1,2,3,0 in bursts of exactly 4 acks each, no idle cycle between bursts.
- Only req[2] held 10 cycles -> 10 consecutive acks, hold_cnt wraps every 4, owner stays 2, out tracks wdata[2] each edge.
- Owner 1 drops req after 2 writes while req[3]=1 -> next cycle owner=3, ack[3]=1, ptr=2; out unchanged on the handoff cycle's missing ack.
- Assert rst=0 mid-burst (asynchronous, between edges) -> ack=0, out=0, owner_valid=0 immediately. After release with req=0100 -> owner=2 (search from ptr=0).
- Random req/wdata for 1000 cycles -> scoreboard: out equals last acked wdata, ack ⊆ req, ack at most one-hot, no requester waits more than (NUM_REQ-1)*MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

  // Arbiter FSM states: nobody owns the register, or one requester owns it.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Widest request vector the generic search helper accepts.
  localparam int unsigned SEARCH_MAX = 32;

  // Result of a rotating priority search.
  typedef struct packed {
    logic        found;
    logic [31:0] index;
  } win_t;

  // First set bit of req at or after start, wrapping modulo n.
  function automatic win_t next_winner(
    input logic [SEARCH_MAX-1:0] req,
    input int unsigned           start,
    input int unsigned           n
  );
    win_t        res;
    int unsigned idx;
    res.found = 1'b0;
    res.index = 32'd0;
    for (int unsigned k = 0; k < SEARCH_MAX; k++) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) begin
          idx = idx - n;
        end else begin
          idx = idx;
        end
        if (!res.found && req[idx[4:0]]) begin
          res.found = 1'b1;
          res.index = idx;
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between the producers and the shared register arbiter.
interface reg_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            ack;
  logic [WIDTH-1:0]              out;
  logic [IDX_W-1:0]              owner;
  logic                          owner_valid;

  modport master (
    output req, wdata,
    input  ack, out, owner, owner_valid
  );

  modport slave (
    input  req, wdata,
    output ack, out, owner, owner_valid
  );
endinterface

// File: rtl/reg_write_arbiter_rr_search.sv
// Combinational rotating-priority search: first requester at or after start.
module rr_search
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [SEARCH_MAX-1:0] req_ext_s;
  win_t                  win_s;
  logic                  unused_idx_s;

  // Zero-extend the request vector to the helper's fixed width.
  always_comb begin
    req_ext_s              = '0;
    req_ext_s[NUM_REQ-1:0] = req;
  end

  assign win_s        = next_winner(req_ext_s, 32'(start), NUM_REQ);
  assign found        = win_s.found;
  assign index        = win_s.index[IDX_W-1:0];
  assign unused_idx_s = ^win_s.index[31:IDX_W];

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between NUM_REQ writers,
// with each ownership limited to MAX_HOLD consecutive writes.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned       IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned       HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic               idle_found_s, rel_found_s;
  logic [IDX_W-1:0]   idle_idx_s, rel_idx_s, owner_inc_s;
  logic               own_req_s, release_s;
  logic [NUM_REQ-1:0] ack_s;

  // Successor of the owner, wrapping at NUM_REQ (which need not be a power of 2).
  assign owner_inc_s = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  rr_search #(.NUM_REQ(NUM_REQ)) u_idle_search (
    .req   (bus.req),
    .start (ptr_q),
    .found (idle_found_s),
    .index (idle_idx_s)
  );

  rr_search #(.NUM_REQ(NUM_REQ)) u_rel_search (
    .req   (bus.req),
    .start (owner_inc_s),
    .found (rel_found_s),
    .index (rel_idx_s)
  );

  // Next-state, ack generation and register write selection.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    out_d     = out_q;
    ack_s     = '0;
    own_req_s = 1'b0;
    release_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_found_s) begin
          state_d = OWNED;
          owner_d = idle_idx_s;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        own_req_s      = bus.req[owner_q];
        ack_s[owner_q] = own_req_s;
        if (own_req_s) begin
          out_d  = bus.wdata[owner_q];
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          out_d  = out_q;
        end
        // A dropped request or a full burst both hand ownership onward;
        // the owner itself is searched last so a lone requester re-wins.
        release_s = !own_req_s || (hold_q == LAST_HOLD);
        if (release_s) begin
          ptr_d  = owner_inc_s;
          hold_d = '0;
          if (rel_found_s) begin
            owner_d = rel_idx_s;
            state_d = OWNED;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, burst counter and shared register flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign bus.ack         = ack_s;
  assign bus.out         = out_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = (state_q == OWNED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed table, corner sequences
// and a randomized run against a behavioural model.
module tb_reg_write_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MH    = 4;
  localparam int BOUND = (N - 1) * MH + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_owner, m_ptr, m_cnt;
  bit           m_valid;
  logic [W-1:0] m_out;

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_cnt = 0; m_valid = 0; m_out = '0;
  endtask

  function automatic int find_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ack(input logic [N-1:0] r);
    logic [N-1:0] a;
    a = '0;
    if (m_valid && r[m_owner]) a[m_owner] = 1'b1;
    return a;
  endfunction

  // Advance the model across one rising edge given this cycle's inputs.
  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0][W-1:0] wd);
    int w;
    bit wrote;
    if (!m_valid) begin
      w = find_from(r, m_ptr);
      if (w >= 0) begin m_valid = 1; m_owner = w; m_cnt = 0; end
    end else begin
      wrote = r[m_owner];
      if (wrote) begin m_out = wd[m_owner]; m_cnt++; end
      if (!wrote || m_cnt == MH) begin
        m_ptr = (m_owner + 1) % N;
        w = find_from(r, m_ptr);
        m_cnt = 0;
        if (w >= 0) m_owner = w;
        else m_valid = 0;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_ack"},   bus.ack, model_ack(bus.req));
    check({tag, "_out"},   bus.out, m_out);
    check({tag, "_valid"}, bus.owner_valid, m_valid);
    check({tag, "_owner"}, bus.owner, m_owner);
  endtask

  // One clock: drive at edge+1, compare at edge+2, then step model at the edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0][W-1:0] wd, input string tag);
    bus.req = r; bus.wdata = wd;
    #1;
    cmp_model(tag);
    @(posedge clk);
    model_edge(r, wd);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.req = '0; bus.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [N-1:0]        req;
    logic [N-1:0][W-1:0] wd;
    logic [N-1:0]        ack;
    logic [W-1:0]        out;
    logic [1:0]          owner;
    logic                valid;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0, input logic [3:0] a,
                              input logic [7:0] o, input logic [1:0] ow, input logic v);
    vec_t t;
    t.req = r; t.wd = {d3, d2, d1, d0}; t.ack = a; t.out = o; t.owner = ow; t.valid = v;
    return t;
  endfunction

  vec_t tbl [10];

  // Immediate one-hot check on ack, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      assert ($onehot0(bus.ack)) else $error("FAIL ack_onehot_assert ack=%b", bus.ack);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0]        r;
    logic [N-1:0][W-1:0] wd;
    logic [N-1:0]        prev_ack;
    logic [W-1:0]        exp_out;
    int                  o;
    int                  wait_c [N];
    int                  max_wait;

    tbl[0] = mk(4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0000, 8'h00, 2'd0, 1'b0);
    tbl[1] = mk(4'b0001, 8'h00, 8'h00, 8'h00, 8'hA5, 4'b0001, 8'h00, 2'd0, 1'b1);
    tbl[2] = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'hA5, 2'd0, 1'b1);
    tbl[3] = mk(4'b1010, 8'h33, 8'h00, 8'h11, 8'h00, 4'b0000, 8'hA5, 2'd0, 1'b0);
    tbl[4] = mk(4'b1010, 8'h33, 8'h00, 8'h12, 8'h00, 4'b0010, 8'hA5, 2'd1, 1'b1);
    tbl[5] = mk(4'b1010, 8'h33, 8'h00, 8'h13, 8'h00, 4'b0010, 8'h12, 2'd1, 1'b1);
    tbl[6] = mk(4'b1000, 8'h33, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h13, 2'd1, 1'b1);
    tbl[7] = mk(4'b1000, 8'h34, 8'h00, 8'h00, 8'h00, 4'b1000, 8'h13, 2'd3, 1'b1);
    tbl[8] = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h34, 2'd3, 1'b1);
    tbl[9] = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h34, 2'd3, 1'b0);

    // Reset state.
    do_reset();
    #1;
    check("reset_ack",   bus.ack, 0);
    check("reset_out",   bus.out, 0);
    check("reset_owner", bus.owner, 0);
    check("reset_valid", bus.owner_valid, 0);
    @(posedge clk); #1;

    // Directed table: first write latency, idle return, handoff on request drop.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req = tbl[i].req; bus.wdata = tbl[i].wd;
      #1;
      check($sformatf("tbl%0d_ack", i),   bus.ack, tbl[i].ack);
      check($sformatf("tbl%0d_out", i),   bus.out, tbl[i].out);
      check($sformatf("tbl%0d_owner", i), bus.owner, tbl[i].owner);
      check($sformatf("tbl%0d_valid", i), bus.owner_valid, tbl[i].valid);
      @(posedge clk);
      model_edge(tbl[i].req, tbl[i].wd);
      #1;
    end

    // All requesting: bursts of MH acks rotating 0,1,2,3,0 with no gap.
    do_reset();
    exp_out = '0;
    for (int k = 0; k <= 20; k++) begin
      for (int i = 0; i < N; i++) wd[i] = W'(i * 16 + k);
      bus.req = 4'b1111; bus.wdata = wd;
      #1;
      check("all_out", bus.out, exp_out);
      if (k == 0) begin
        check("all_idle_ack", bus.ack, 0);
      end else begin
        o = ((k - 1) / MH) % N;
        check($sformatf("all_k%0d_owner", k), bus.owner, o);
        check($sformatf("all_k%0d_ack", k), bus.ack, 1 << o);
        exp_out = wd[o];
      end
      @(posedge clk);
      model_edge(4'b1111, wd);
      #1;
    end

    // Lone requester keeps re-winning across hold expiry.
    do_reset();
    exp_out = '0;
    for (int k = 0; k <= 10; k++) begin
      wd = '0;
      wd[2] = W'(8'h40 + k);
      bus.req = 4'b0100; bus.wdata = wd;
      #1;
      check("solo_out", bus.out, exp_out);
      check($sformatf("solo_k%0d_ack", k), bus.ack, (k == 0) ? 0 : 4'b0100);
      if (k > 0) begin
        check("solo_owner", bus.owner, 2);
        exp_out = wd[2];
      end
      @(posedge clk);
      model_edge(4'b0100, wd);
      #1;
    end

    // Asynchronous reset in the middle of a burst.
    do_reset();
    wd = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int k = 0; k < 3; k++) cycle(4'b1111, wd, "mid");
    bus.req = 4'b1111; bus.wdata = wd;
    #1;
    check("mid_pre_ack", bus.ack, 4'b0001);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ack",   bus.ack, 0);
    check("mid_rst_out",   bus.out, 0);
    check("mid_rst_valid", bus.owner_valid, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    wd = {8'h00, 8'h77, 8'h00, 8'h00};
    cycle(4'b0100, wd, "post_rst_idle");
    bus.req = 4'b0100; bus.wdata = wd;
    #1;
    check("post_rst_owner", bus.owner, 2);
    check("post_rst_ack",   bus.ack, 4'b0100);
    @(posedge clk);
    model_edge(4'b0100, wd);
    #1;

    // Randomized run against the model with a starvation bound.
    do_reset();
    r = '0; prev_ack = '0; max_wait = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i] && !prev_ack[i]) r[i] = 1'b1;
        else r[i] = ($urandom_range(0, 99) < 45);
        wd[i] = W'($urandom);
      end
      bus.req = r; bus.wdata = wd;
      #1;
      cmp_model("rnd");
      check("rnd_subset", bus.ack & ~r, 0);
      check("rnd_onehot", $onehot0(bus.ack), 1);
      for (int i = 0; i < N; i++) begin
        if (r[i] && !bus.ack[i]) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      prev_ack = model_ack(r);
      @(posedge clk);
      model_edge(r, wd);
      #1;
    end
    check("rnd_max_wait_ok", (max_wait <= BOUND) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
